// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder.
// Holds the group width, the per-stage pipeline record and configuration checks.
package cla_pkg;

   localparam int unsigned CLA_GROUP     = 4;
   localparam int unsigned CLA_MAX_WIDTH = 128;

   // Pipeline record: finished low sum bits plus skewed, not-yet-added operand bits.
   typedef struct packed {
      logic                     valid;
      logic                     carry;
      logic [CLA_MAX_WIDTH-1:0] sum;
      logic [CLA_MAX_WIDTH-1:0] a;
      logic [CLA_MAX_WIDTH-1:0] b;
   } cla_stage_t;

   function automatic bit cla_cfg_ok(input int unsigned width, input int unsigned stages);
      if (stages == 0 || width == 0 || width > CLA_MAX_WIDTH) begin
         return 1'b0;
      end
      return (width % (CLA_GROUP * stages)) == 0;
   endfunction

   // Flattened lookahead carry into bit k of a group (k == CLA_GROUP gives carry out).
   function automatic logic cla_carry_at(input logic [CLA_GROUP-1:0] p,
                                         input logic [CLA_GROUP-1:0] g,
                                         input logic                 cin,
                                         input int unsigned          k);
      logic c;
      logic t;
      c = cin;
      for (int unsigned i = 0; i < k; i++) begin
         c = c & p[i];
      end
      for (int unsigned i = 0; i < k; i++) begin
         t = g[i];
         for (int unsigned m = i + 1; m < k; m++) begin
            t = t & p[m];
         end
         c = c | t;
      end
      return c;
   endfunction

endpackage

// File: rtl/cla_pipe_adder_slice.sv
// Combinational W-bit carry-lookahead adder built from 4-bit groups.
// Lookahead inside each group and across groups; exposes carry into the MSB.
module cla_slice
   import cla_pkg::*;
#(
   parameter int unsigned W = 16
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_cin,
   output logic [W-1:0] o_sum,
   output logic         o_cout,
   output logic         o_cmsb
);

   localparam int unsigned NG = W / CLA_GROUP;

   logic [W-1:0]  w_p;
   logic [W-1:0]  w_g;
   logic [W-1:0]  w_c;
   logic [NG-1:0] w_gp;
   logic [NG-1:0] w_gg;
   logic [NG:0]   w_gc;

   assign w_p = i_a ^ i_b;
   assign w_g = i_a & i_b;

   // Group propagate / generate.
   always_comb begin : group_pg
      w_gp = '0;
      w_gg = '0;
      for (int j = 0; j < int'(NG); j++) begin
         w_gp[j] = &w_p[j*CLA_GROUP +: CLA_GROUP];
         w_gg[j] = cla_carry_at(w_p[j*CLA_GROUP +: CLA_GROUP],
                                w_g[j*CLA_GROUP +: CLA_GROUP], 1'b0, CLA_GROUP);
      end
   end

   // Flattened lookahead across groups: no ripple between groups.
   always_comb begin : group_carry
      logic v_t;
      w_gc = '0;
      v_t  = 1'b0;
      for (int j = 0; j <= int'(NG); j++) begin
         v_t = i_cin;
         for (int i = 0; i < j; i++) begin
            v_t = v_t & w_gp[i];
         end
         w_gc[j] = v_t;
         for (int i = 0; i < j; i++) begin
            v_t = w_gg[i];
            for (int m = i + 1; m < j; m++) begin
               v_t = v_t & w_gp[m];
            end
            w_gc[j] = w_gc[j] | v_t;
         end
      end
   end

   always_comb begin : bit_carry
      w_c = '0;
      for (int j = 0; j < int'(NG); j++) begin
         for (int i = 0; i < int'(CLA_GROUP); i++) begin
            w_c[j*CLA_GROUP + i] = cla_carry_at(w_p[j*CLA_GROUP +: CLA_GROUP],
                                                w_g[j*CLA_GROUP +: CLA_GROUP],
                                                w_gc[j], i);
         end
      end
   end

   assign o_sum  = w_p ^ w_c;
   assign o_cout = w_gc[NG];
   assign o_cmsb = w_c[W-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor, one SLICE-wide stage per pipeline stage.
// Define CLA_PIPE_FLAGS_EN to build registered zero/neg/ovf flags; otherwise they are 0.
module cla_pipe_adder
   import cla_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_zero,
   output logic             out_neg,
   output logic             out_ovf
);

   localparam int unsigned SLICE = WIDTH / STAGES;
   localparam int unsigned LAST  = STAGES - 1;

   if (!cla_cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
      $error("cla_pipe_adder: WIDTH must be a nonzero multiple of 4*STAGES");
   end

   cla_stage_t       r_stage [STAGES];
   cla_stage_t       w_src   [STAGES];
   cla_stage_t       w_nxt   [STAGES];
   logic [WIDTH-1:0] w_sl_a;
   logic [WIDTH-1:0] w_sl_b;
   logic [WIDTH-1:0] w_sl_sum;
   logic [STAGES-1:0] w_sl_cin;
   logic [STAGES-1:0] w_sl_cout;
   logic [STAGES-1:0] w_cmsb;
   logic             w_adv;
   logic             w_unused_cmsb;

   // Whole pipeline advances together; a full, stalled output holds every stage.
   assign w_adv    = !r_stage[LAST].valid || out_ready;
   assign in_ready = rst || w_adv;

   // Stage inputs: stage 0 takes the effective operands, later stages the previous register.
   always_comb begin : stage_src
      w_src[0]                = '0;
      w_src[0].valid          = in_valid;
      w_src[0].carry          = in_sub ? ~in_cin : in_cin;
      w_src[0].a[WIDTH-1:0]   = in_a;
      w_src[0].b[WIDTH-1:0]   = in_sub ? ~in_b : in_b;
      for (int k = 1; k < int'(STAGES); k++) begin
         w_src[k] = r_stage[k-1];
      end
      w_sl_a   = '0;
      w_sl_b   = '0;
      w_sl_cin = '0;
      for (int k = 0; k < int'(STAGES); k++) begin
         w_sl_a[k*SLICE +: SLICE] = w_src[k].a[k*SLICE +: SLICE];
         w_sl_b[k*SLICE +: SLICE] = w_src[k].b[k*SLICE +: SLICE];
         w_sl_cin[k]              = w_src[k].carry;
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_slice
      cla_slice #(
         .W (SLICE)
      ) u_slice (
         .i_a    (w_sl_a[k*SLICE +: SLICE]),
         .i_b    (w_sl_b[k*SLICE +: SLICE]),
         .i_cin  (w_sl_cin[k]),
         .o_sum  (w_sl_sum[k*SLICE +: SLICE]),
         .o_cout (w_sl_cout[k]),
         .o_cmsb (w_cmsb[k])
      );
   end

   // Merge each slice result into its record; operand bits above ride along untouched.
   always_comb begin : stage_nxt
      for (int k = 0; k < int'(STAGES); k++) begin
         w_nxt[k]                        = w_src[k];
         w_nxt[k].sum[k*SLICE +: SLICE]  = w_sl_sum[k*SLICE +: SLICE];
         w_nxt[k].carry                  = w_sl_cout[k];
      end
   end

   always_ff @(posedge clk) begin : stage_regs
      for (int k = 0; k < int'(STAGES); k++) begin
         if (rst) begin
            r_stage[k] <= '0;
         end else if (w_adv) begin
            r_stage[k] <= w_nxt[k];
         end
      end
   end

   assign out_valid = r_stage[LAST].valid;
   assign out_sum   = r_stage[LAST].sum[WIDTH-1:0];
   assign out_cout  = r_stage[LAST].carry;

   // Only the last slice's MSB carry matters, and only when flags are built.
   assign w_unused_cmsb = ^w_cmsb;

`ifdef CLA_PIPE_FLAGS_EN
   logic             r_zero;
   logic             r_neg;
   logic             r_ovf;
   logic [WIDTH-1:0] w_res;

   assign w_res = w_nxt[LAST].sum[WIDTH-1:0];

   always_ff @(posedge clk) begin : flag_regs
      if (rst) begin
         r_zero <= 1'b0;
         r_neg  <= 1'b0;
         r_ovf  <= 1'b0;
      end else if (w_adv) begin
         r_zero <= (w_res == '0);
         r_neg  <= w_res[WIDTH-1];
         r_ovf  <= w_cmsb[LAST] ^ w_sl_cout[LAST];
      end
   end

   assign out_zero = r_zero;
   assign out_neg  = r_neg;
   assign out_ovf  = r_ovf;
`else
   assign out_zero = 1'b0;
   assign out_neg  = 1'b0;
   assign out_ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed self-checking bench for cla_pipe_adder (WIDTH=32, STAGES=2).
module tb_cla_pipe_adder;

   localparam int unsigned WIDTH  = 32;
   localparam int unsigned STAGES = 2;
`ifdef CLA_PIPE_FLAGS_EN
   localparam bit FL = 1'b1;
`else
   localparam bit FL = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             in_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_zero;
   logic             out_neg;
   logic             out_ovf;

   int checks = 0;
   int errors = 0;

   cla_pipe_adder #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_zero  (out_zero),
      .out_neg   (out_neg),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_word(input string tag, input logic [WIDTH-1:0] obs,
                             input logic [WIDTH-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // One isolated beat: checks acceptance, latency and every result field.
   task automatic run_one(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input logic sub, input logic [WIDTH-1:0] es,
                          input logic ec, input logic ez, input logic en, input logic eo);
      @(negedge clk);
      in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      check_bit({tag, "_rdy"}, in_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check_bit({tag, "_early"}, out_valid, 1'b0);
      @(posedge clk);
      @(negedge clk);
      #1;
      check_bit ({tag, "_valid"}, out_valid, 1'b1);
      check_word({tag, "_sum"},   out_sum,   es);
      check_bit ({tag, "_cout"},  out_cout,  ec);
      check_bit ({tag, "_zero"},  out_zero,  ez & FL);
      check_bit ({tag, "_neg"},   out_neg,   en & FL);
      check_bit ({tag, "_ovf"},   out_ovf,   eo & FL);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "simulation did not finish");
   end

   initial begin : stim
      logic [WIDTH-1:0] bp_a   [4];
      logic [WIDTH-1:0] bp_b   [4];
      logic             bp_sub [4];
      logic [WIDTH-1:0] bp_exp [4];
      logic [9:0]       rdy_tbl;
      logic [9:0]       ov_tbl;
      int               tx;
      int               rx;
      logic             acc;

      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check_bit("rst_in_ready", in_ready, 1'b1);
      check_bit("rst_out_valid", out_valid, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      #1;
      check_bit ("post_rst_in_ready", in_ready, 1'b1);
      check_bit ("post_rst_valid",    out_valid, 1'b0);
      check_word("post_rst_sum",      out_sum, 32'h0);
      check_bit ("post_rst_cout",     out_cout, 1'b0);
      check_bit ("post_rst_zero",     out_zero, 1'b0);
      check_bit ("post_rst_neg",      out_neg, 1'b0);
      check_bit ("post_rst_ovf",      out_ovf, 1'b0);

      run_one("wrap",     32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0);
      run_one("boundary", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0);
      run_one("sub_neg",  32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0);
      run_one("sub_bin",  32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0);
      run_one("ovf_pos",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1);
      run_one("mixed",    32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'hACF1_3569, 1'b0, 1'b0, 1'b1, 1'b0);
      run_one("ovf_sub",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);

      // Four back-to-back beats, output stalled for cycles 2..4.
      bp_a[0] = 32'h0000_0001; bp_b[0] = 32'h0000_0002; bp_sub[0] = 1'b0; bp_exp[0] = 32'h0000_0003;
      bp_a[1] = 32'h0000_0010; bp_b[1] = 32'h0000_0020; bp_sub[1] = 1'b0; bp_exp[1] = 32'h0000_0030;
      bp_a[2] = 32'hFFFF_0000; bp_b[2] = 32'h0001_0000; bp_sub[2] = 1'b0; bp_exp[2] = 32'h0000_0000;
      bp_a[3] = 32'h0000_0100; bp_b[3] = 32'h0000_0001; bp_sub[3] = 1'b1; bp_exp[3] = 32'h0000_00FF;
      rdy_tbl = 10'b11_1110_0011;
      ov_tbl  = 10'b01_1111_1100;
      tx = 0;
      rx = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         out_ready = rdy_tbl[c];
         in_valid  = (tx < 4);
         if (tx < 4) begin
            in_a = bp_a[tx]; in_b = bp_b[tx]; in_sub = bp_sub[tx]; in_cin = 1'b0;
         end
         #1;
         check_bit($sformatf("bp_in_ready_c%0d", c), in_ready, rdy_tbl[c]);
         check_bit($sformatf("bp_out_valid_c%0d", c), out_valid, ov_tbl[c]);
         if (out_valid && rx < 4) begin
            check_word($sformatf("bp_sum_r%0d_c%0d", rx, c), out_sum, bp_exp[rx]);
         end
         acc = in_valid && in_ready;
         if (out_valid && out_ready) rx++;
         @(posedge clk);
         if (acc) tx++;
      end
      in_valid = 1'b0;
      check_word("bp_sent",     32'(tx), 32'd4);
      check_word("bp_received", 32'(rx), 32'd4);

      // Reset with two beats in flight and the output stalled.
      @(negedge clk);
      in_a = 32'h0000_0001; in_b = 32'h0000_0001; in_sub = 1'b0; in_cin = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_a = 32'h0000_0002; in_b = 32'h0000_0002;
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
      #1;
      check_bit("inflight_valid", out_valid, 1'b1);
      check_bit("rst_stall_ready", in_ready, 1'b1);
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b1;
      #1;
      check_bit("rst_drop_c0", out_valid, 1'b0);
      @(negedge clk);
      #1;
      check_bit("rst_drop_c1", out_valid, 1'b0);
      @(negedge clk);
      #1;
      check_bit("rst_drop_c2", out_valid, 1'b0);
      run_one("after_rst", 32'h0000_00A5, 32'h0000_005A, 1'b0, 1'b0, 32'h0000_00FF, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
